bus_timer_slave: RTL

- Bus slave (responder) on the shared bus: it decodes chip select and address strobe, inserts programmable wait states, and answers with read data and an active-low ready.
- Hosts a 32-bit interval timer with four word registers and a level interrupt output.
- Connects to one slave port of the bus (sN_cs_, sN_rd_data, sN_rdy_) and to the shared s_addr/s_as_/s_rw/s_wr_data.

---
 rtl/bus_timer_slave.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bus_timer_slave.sv
// Bus responder with programmable wait states hosting a 32-bit interval timer.
// Optional tick prescaler enabled by defining TIMER_PRESCALER_EN.
module bus_timer_slave #(
  parameter int WAIT_CYCLES = 1,
  parameter int PRESCALE    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cs_,
  input  logic        i_as_,
  input  logic        i_rw,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_rd_data,
  output logic        o_rdy_,
  output logic        o_irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_wait_cnt;
  logic [1:0]  r_addr;
  logic        r_rw;
  logic [31:0] r_wdata;
  logic [31:0] r_ack_data;
  logic [31:0] r_rd_data;
  logic        r_rdy_;

  logic        r_start;
  logic        r_periodic;
  logic        r_expired;
  logic [31:0] r_expire;
  logic [31:0] r_counter;

  logic        w_accept;
  logic        w_enter_ack;
  logic        w_wr_en;
  logic [1:0]  w_rd_sel;
  logic [31:0] w_rd_mux;
  logic        w_tick;
  logic        w_expire_hit;
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic        w_wr_expire;
  logic        w_wr_counter;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (!i_cs_ && !i_as_) w_state_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (r_wait_cnt == 4'd0) w_state_next = ST_ACK;
      ST_ACK:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM-derived controls
  always_comb begin
    w_accept    = (r_state == ST_IDLE) && !i_cs_ && !i_as_;
    w_enter_ack = (w_state_next == ST_ACK) && (r_state != ST_ACK);
    w_wr_en     = (r_state == ST_ACK) && !r_rw;
    // With zero wait states ACK is entered on the accept edge, before r_addr holds the address.
    w_rd_sel    = (r_state == ST_IDLE) ? i_addr : r_addr;
  end

  always_comb begin
    w_rd_mux = 32'h0;
    case (w_rd_sel)
      2'd0: w_rd_mux = {30'h0, r_periodic, r_start};
      2'd1: w_rd_mux = {31'h0, r_expired};
      2'd2: w_rd_mux = r_expire;
      2'd3: w_rd_mux = r_counter;
      default: w_rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wait_cnt <= 4'd0;
      r_addr     <= 2'd0;
      r_rw       <= 1'b0;
      r_wdata    <= 32'h0;
      r_ack_data <= 32'h0;
      r_rd_data  <= 32'h0;
      r_rdy_     <= 1'b1;
    end else begin
      if (w_accept) begin
        r_addr     <= i_addr;
        r_rw       <= i_rw;
        r_wdata    <= i_wr_data;
        r_wait_cnt <= WAIT_LOAD;
      end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_enter_ack) r_ack_data <= w_rd_mux;
      r_rdy_    <= (r_state != ST_ACK);
      r_rd_data <= (r_state == ST_ACK && r_rw) ? r_ack_data : 32'h0;
    end
  end

  assign o_rdy_    = r_rdy_;
  assign o_rd_data = r_rd_data;
  assign o_irq     = r_expired;

  assign w_wr_ctrl    = w_wr_en && (r_addr == 2'd0);
  assign w_wr_status  = w_wr_en && (r_addr == 2'd1);
  assign w_wr_expire  = w_wr_en && (r_addr == 2'd2);
  assign w_wr_counter = w_wr_en && (r_addr == 2'd3);

`ifdef TIMER_PRESCALER_EN
  localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [DIV_W-1:0] r_div;
  logic             w_div_wrap;

  assign w_div_wrap = (r_div == DIV_W'(PRESCALE - 1));
  assign w_tick     = r_start && w_div_wrap;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                       r_div <= '0;
    else if (!r_start || w_wr_counter) r_div <= '0;
    else if (w_div_wrap)               r_div <= '0;
    else                               r_div <= r_div + 1'b1;
  end
`else
  assign w_tick = r_start;
`endif

  assign w_expire_hit = w_tick && (r_counter == r_expire);

  // Bus writes take priority over timer updates, except that an expiry always sets the flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_start    <= 1'b0;
      r_periodic <= 1'b0;
      r_expired  <= 1'b0;
      r_expire   <= 32'h0;
      r_counter  <= 32'h0;
    end else begin
      if (w_wr_ctrl) begin
        r_start    <= r_wdata[0];
        r_periodic <= r_wdata[1];
      end else if (w_expire_hit && !r_periodic) begin
        r_start <= 1'b0;
      end

      if (w_expire_hit)                       r_expired <= 1'b1;
      else if (w_wr_status && !r_wdata[0])    r_expired <= 1'b0;

      if (w_wr_expire) r_expire <= r_wdata;

      if (w_wr_counter)      r_counter <= r_wdata;
      else if (w_expire_hit) r_counter <= 32'h0;
      else if (w_tick)       r_counter <= r_counter + 32'd1;
    end
  end

endmodule
